// File: rtl/ctrl_decode_stage_if.sv
// ---------------------------------------------------------------------------
// ctrl_decode_stage_if
//  Bus between the ID-stage control unit and its surroundings.
//  slave  : view taken by ctrl_decode_stage (instruction/handshake in,
//           ID/EX control bundle and status out).
//  master : view taken by the driver of ID (pipeline datapath / testbench).
//  Signals:
//   id_instr, id_valid, ex_stall, flush      master -> slave
//   id_stall (combinational), ex_* controls,
//   mdu_busy, halted, illegal                slave -> master
// ---------------------------------------------------------------------------
interface ctrl_decode_stage_if #(
   parameter int unsigned ALU_OP_W = 4
) ();

   logic [31:0]         id_instr;
   logic                id_valid;
   logic                ex_stall;
   logic                flush;
   logic                id_stall;
   logic                ex_valid;
   logic [ALU_OP_W-1:0] ex_alu_op;
   logic                ex_alu_src_b;
   logic                ex_reg_write;
   logic                ex_reg_dst;
   logic                ex_mem_to_reg;
   logic                ex_mem_write;
   logic                ex_signed_ext;
   logic                ex_beq;
   logic                ex_bne;
   logic                ex_blez;
   logic                ex_jmp;
   logic                ex_jal;
   logic                ex_jr;
   logic                ex_shamt_sel;
   logic                ex_syscall;
   logic                ex_hilo_rd;
   logic [1:0]          ex_ram_sel;
   logic                ex_mdu_start;
   logic                mdu_busy;
   logic                halted;
   logic                illegal;

   modport master (
      output id_instr, id_valid, ex_stall, flush,
      input  id_stall, ex_valid, ex_alu_op, ex_alu_src_b, ex_reg_write,
             ex_reg_dst, ex_mem_to_reg, ex_mem_write, ex_signed_ext, ex_beq,
             ex_bne, ex_blez, ex_jmp, ex_jal, ex_jr, ex_shamt_sel, ex_syscall,
             ex_hilo_rd, ex_ram_sel, ex_mdu_start, mdu_busy, halted, illegal
   );

   modport slave (
      input  id_instr, id_valid, ex_stall, flush,
      output id_stall, ex_valid, ex_alu_op, ex_alu_src_b, ex_reg_write,
             ex_reg_dst, ex_mem_to_reg, ex_mem_write, ex_signed_ext, ex_beq,
             ex_bne, ex_blez, ex_jmp, ex_jal, ex_jr, ex_shamt_sel, ex_syscall,
             ex_hilo_rd, ex_ram_sel, ex_mdu_start, mdu_busy, halted, illegal
   );

endinterface

// File: rtl/ctrl_decode_stage.sv
// ---------------------------------------------------------------------------
// ctrl_decode_stage
//  Registered ID/EX control unit of the 5-stage MIPS pipeline. Decodes the ID
//  instruction, latches the control bundle into ID/EX, handles stall/flush,
//  interlocks MFHI/MFLO and back-to-back MULT/DIV against a multi-cycle MDU
//  busy counter, and freezes the core after a SYSCALL retires.
//  Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ctrl_decode_stage_if.slave (instruction in, ID/EX controls out,
//         id_stall is the only combinational output)
//  Parameters: ALU_OP_W (>=4), MDU_LAT (>=1), CNT_W (2**CNT_W > MDU_LAT)
//  Build option: CTRL_ILLEGAL_TRAP_EN -- when defined, an undecodable valid
//   instruction becomes a bubble and raises a sticky illegal flag that stalls
//   ID; when undefined it retires as a NOP and illegal stays 0.
// ---------------------------------------------------------------------------
module ctrl_decode_stage #(
   parameter int unsigned ALU_OP_W = 4,
   parameter int unsigned MDU_LAT  = 4,
   parameter int unsigned CNT_W    = 3
) (
   input logic                clk,
   input logic                rst,
   ctrl_decode_stage_if.slave bus
);

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       mem_write;
      logic       signed_ext;
      logic       beq;
      logic       bne;
      logic       blez;
      logic       jmp;
      logic       jal;
      logic       jr;
      logic       shamt_sel;
      logic       syscall;
      logic       hilo_rd;
      logic [1:0] ram_sel;
   } ctrl_t;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MDU_BUSY = 2'd1,
      S_HALT     = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mdu_busy_q;
   logic             mdu_start_q;
   logic             illegal_q;
   ctrl_t            ex_q, ex_d;
   logic             ex_valid_q, ex_valid_d;

   ctrl_t            dec;
   logic             known, is_mdu, is_hilo, is_sys;
   logic             hazard, id_stall_c, load;
   logic             take_mdu, take_sys, set_ill;

   logic [5:0] opcode, funct;
   logic [4:0] rt;
   logic       unused_instr_bits;

   assign opcode            = bus.id_instr[31:26];
   assign rt                = bus.id_instr[20:16];
   assign funct             = bus.id_instr[5:0];
   assign unused_instr_bits = ^{bus.id_instr[25:21], bus.id_instr[15:6]};

   // Instruction decode into the control bundle plus hazard classification
   always_comb begin
      dec     = '0;
      known   = 1'b1;
      is_mdu  = 1'b0;
      is_hilo = 1'b0;
      is_sys  = 1'b0;
      case (opcode)
         6'h00: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
            case (funct)
               6'h00: dec.shamt_sel = 1'b1;
               6'h02: begin dec.alu_op = 4'd2; dec.shamt_sel = 1'b1; end
               6'h03: begin dec.alu_op = 4'd1; dec.shamt_sel = 1'b1; end
               6'h06: dec.alu_op = 4'd2;
               6'h20, 6'h21: dec.alu_op = 4'd5;
               6'h22: dec.alu_op = 4'd6;
               6'h24: dec.alu_op = 4'd7;
               6'h25: dec.alu_op = 4'd8;
               6'h26: dec.alu_op = 4'd9;
               6'h27: dec.alu_op = 4'd10;
               6'h2A: dec.alu_op = 4'd11;
               6'h2B: dec.alu_op = 4'd12;
               6'h10, 6'h12: begin
                  dec.hilo_rd = 1'b1;
                  is_hilo     = 1'b1;
               end
               6'h08: begin
                  dec           = '0;
                  dec.jr        = 1'b1;
               end
               6'h0C: begin
                  dec           = '0;
                  dec.syscall   = 1'b1;
                  is_sys        = 1'b1;
               end
               // MDU ops only launch the unit; they write no GPR
               6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  dec    = '0;
                  is_mdu = 1'b1;
               end
               default: begin
                  dec   = '0;
                  known = 1'b0;
               end
            endcase
         end
         6'h02: dec.jmp = 1'b1;
         6'h03: begin dec.jal = 1'b1; dec.reg_write = 1'b1; end
         6'h04: dec.beq = 1'b1;
         6'h05: dec.bne = 1'b1;
         6'h06: begin
            if (rt == 5'd0) begin
               dec.blez   = 1'b1;
               dec.alu_op = 4'd11;
            end else begin
               known = 1'b0;
            end
         end
         6'h08, 6'h09, 6'h0A: begin
            dec.alu_op     = (opcode == 6'h0A) ? 4'd11 : 4'd5;
            dec.alu_src_b  = 1'b1;
            dec.reg_write  = 1'b1;
            dec.signed_ext = 1'b1;
         end
         6'h0C, 6'h0D: begin
            dec.alu_op    = (opcode == 6'h0C) ? 4'd7 : 4'd8;
            dec.alu_src_b = 1'b1;
            dec.reg_write = 1'b1;
         end
         6'h23, 6'h24: begin
            dec.alu_op     = 4'd5;
            dec.alu_src_b  = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.signed_ext = 1'b1;
            dec.ram_sel    = (opcode == 6'h24) ? 2'b11 : 2'b00;
         end
         6'h2B: begin
            dec.alu_op     = 4'd5;
            dec.alu_src_b  = 1'b1;
            dec.mem_write  = 1'b1;
            dec.signed_ext = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   // Interlock, load/bubble selection and busy-counter next value
   always_comb begin
      hazard     = bus.id_valid & (is_mdu | is_hilo);
      // a flushed MDU/HI-LO reader is squashed anyway, so it need not wait
      id_stall_c = (state_q == S_HALT) | (mdu_busy_q & hazard & ~bus.flush)
                   | (TRAP_EN & illegal_q);
      load       = bus.id_valid & ~bus.flush & ~id_stall_c;
      ex_d       = '0;
      ex_valid_d = 1'b0;
      if (load & known) begin
         ex_d       = dec;
         ex_valid_d = 1'b1;
      end else if (load & ~TRAP_EN) begin
         ex_valid_d = 1'b1;
      end
      take_mdu = load & is_mdu;
      take_sys = load & is_sys;
      set_ill  = load & ~known & TRAP_EN;
      if (take_mdu) begin
         cnt_d = CNT_W'(MDU_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // ID/EX register, busy counter and RUN/MDU_BUSY/HALT FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         mdu_busy_q  <= 1'b0;
         mdu_start_q <= 1'b0;
         illegal_q   <= 1'b0;
         ex_q        <= '0;
         ex_valid_q  <= 1'b0;
      end else if (bus.ex_stall) begin
         // held register must not look like a second launch
         mdu_start_q <= 1'b0;
      end else begin
         ex_q        <= ex_d;
         ex_valid_q  <= ex_valid_d;
         mdu_start_q <= take_mdu;
         cnt_q       <= cnt_d;
         mdu_busy_q  <= (cnt_d != '0);
         illegal_q   <= illegal_q | set_ill;
         case (state_q)
            S_RUN: begin
               if (take_sys)      state_q <= S_HALT;
               else if (take_mdu) state_q <= S_MDU_BUSY;
            end
            S_MDU_BUSY: begin
               if (take_sys)          state_q <= S_HALT;
               else if (cnt_d == '0)  state_q <= S_RUN;
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_RUN;
         endcase
      end
   end

   assign bus.id_stall      = id_stall_c;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_alu_op     = ALU_OP_W'(ex_q.alu_op);
   assign bus.ex_alu_src_b  = ex_q.alu_src_b;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_reg_dst    = ex_q.reg_dst;
   assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.ex_signed_ext = ex_q.signed_ext;
   assign bus.ex_beq        = ex_q.beq;
   assign bus.ex_bne        = ex_q.bne;
   assign bus.ex_blez       = ex_q.blez;
   assign bus.ex_jmp        = ex_q.jmp;
   assign bus.ex_jal        = ex_q.jal;
   assign bus.ex_jr         = ex_q.jr;
   assign bus.ex_shamt_sel  = ex_q.shamt_sel;
   assign bus.ex_syscall    = ex_q.syscall;
   assign bus.ex_hilo_rd    = ex_q.hilo_rd;
   assign bus.ex_ram_sel    = ex_q.ram_sel;
   assign bus.ex_mdu_start  = mdu_start_q;
   assign bus.mdu_busy      = mdu_busy_q;
   assign bus.halted        = (state_q == S_HALT);
   assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_ctrl_decode_stage
//  Drives ctrl_decode_stage through directed scenarios and random traffic,
//  comparing every cycle against a table-driven instruction reference and an
//  abstract pipeline model (busy cycles left, halted, illegal flags).
// ---------------------------------------------------------------------------
module tb_ctrl_decode_stage;

   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned MDU_LAT  = 4;
   localparam int unsigned CNT_W    = 3;
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam int K_NORM = 0, K_MDU = 1, K_HILO = 2, K_SYS = 3, K_ILL = 4;

   localparam logic [16:0] F_SRCB = 17'd1 << 16;
   localparam logic [16:0] F_RW   = 17'd1 << 15;
   localparam logic [16:0] F_RD   = 17'd1 << 14;
   localparam logic [16:0] F_M2R  = 17'd1 << 13;
   localparam logic [16:0] F_MW   = 17'd1 << 12;
   localparam logic [16:0] F_SEXT = 17'd1 << 11;
   localparam logic [16:0] F_BEQ  = 17'd1 << 10;
   localparam logic [16:0] F_BNE  = 17'd1 << 9;
   localparam logic [16:0] F_BLEZ = 17'd1 << 8;
   localparam logic [16:0] F_J    = 17'd1 << 7;
   localparam logic [16:0] F_JAL  = 17'd1 << 6;
   localparam logic [16:0] F_JR   = 17'd1 << 5;
   localparam logic [16:0] F_SH   = 17'd1 << 4;
   localparam logic [16:0] F_SYS  = 17'd1 << 3;
   localparam logic [16:0] F_HILO = 17'd1 << 2;
   localparam logic [16:0] F_BYTE = 17'd3;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      bit          rtype;
      int          rtm;     // 0 random rt, 1 rt=0, 2 rt!=0
      logic [20:0] exp;
      int          kind;
   } ent_t;

   ent_t tbl[$];
   int   norm_idx[$];
   int   ill_idx[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_decode_stage_if #(.ALU_OP_W(ALU_OP_W)) bus ();

   ctrl_decode_stage #(
      .ALU_OP_W (ALU_OP_W),
      .MDU_LAT  (MDU_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt = 0;
   int start_cnt = 0;

   // reference model state
   bit          m_valid, m_start, m_halt, m_ill;
   logic [20:0] m_exp;
   int          m_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void add_e(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                 input bit r, input int rtm, input logic [3:0] alu,
                                 input logic [16:0] fl, input int k);
      ent_t e;
      e.name = nm; e.op = op; e.fn = fn; e.rtype = r; e.rtm = rtm;
      e.exp = {alu, fl}; e.kind = k;
      tbl.push_back(e);
      if (k == K_ILL)      ill_idx.push_back(tbl.size() - 1);
      else if (k != K_SYS) norm_idx.push_back(tbl.size() - 1);
   endfunction

   function automatic int find(input string nm);
      foreach (tbl[i]) if (tbl[i].name == nm) return i;
      return 0;
   endfunction

   function automatic logic [31:0] gen(input int ei);
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
      imm = 16'($urandom);
      if (tbl[ei].rtm == 1)      rt = 5'd0;
      else if (tbl[ei].rtm == 2) rt = 5'($urandom_range(1, 31));
      if (tbl[ei].rtype) return {6'h00, rs, rt, rd, sh, tbl[ei].fn};
      return {tbl[ei].op, rs, rt, imm};
   endfunction

   function automatic logic [20:0] obs();
      return {bus.ex_alu_op[3:0], bus.ex_alu_src_b, bus.ex_reg_write, bus.ex_reg_dst,
              bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_signed_ext, bus.ex_beq,
              bus.ex_bne, bus.ex_blez, bus.ex_jmp, bus.ex_jal, bus.ex_jr,
              bus.ex_shamt_sel, bus.ex_syscall, bus.ex_hilo_rd, bus.ex_ram_sel};
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0; m_start = 1'b0; m_halt = 1'b0; m_ill = 1'b0;
      m_exp = '0; m_busy = 0;
   endfunction

   // One clock: apply inputs, check outputs mid-cycle, advance the model at the edge
   task automatic cycle(input int ei, input logic [31:0] ins, input bit v,
                        input bit es, input bit fl, input bit r);
      bit exp_stall, load;
      int k;
      k = tbl[ei].kind;
      bus.id_instr = ins; bus.id_valid = v; bus.ex_stall = es; bus.flush = fl; rst = r;
      exp_stall = m_halt || (m_busy > 0 && v && (k == K_MDU || k == K_HILO) && !fl)
                  || (TRAP && m_ill);
      @(negedge clk);
      chk("ex_ctrl",      32'(obs()),             32'(m_exp));
      chk("ex_valid",     32'(bus.ex_valid),      32'(m_valid));
      chk("ex_mdu_start", 32'(bus.ex_mdu_start),  32'(m_start));
      chk("mdu_busy",     32'(bus.mdu_busy),      32'(m_busy > 0));
      chk("halted",       32'(bus.halted),        32'(m_halt));
      chk("illegal",      32'(bus.illegal),       32'(m_ill));
      chk("id_stall",     32'(bus.id_stall),      32'(exp_stall));
      busy_cnt  += int'(bus.mdu_busy);
      start_cnt += int'(bus.ex_mdu_start);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (es) begin
         m_start = 1'b0;
      end else begin
         if (m_busy > 0) m_busy--;
         m_start = 1'b0;
         load = v && !fl && !exp_stall;
         if (!load) begin
            m_valid = 1'b0; m_exp = '0;
         end else if (k == K_ILL) begin
            m_valid = !TRAP; m_exp = '0;
            if (TRAP) m_ill = 1'b1;
         end else begin
            m_valid = 1'b1; m_exp = tbl[ei].exp;
            if (k == K_MDU) begin m_busy = MDU_LAT; m_start = 1'b1; end
            if (k == K_SYS) m_halt = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int e_add, e_mult, e_multu, e_mflo, e_sys, e_ill, ei;
      add_e("ADD",   6'h00, 6'h20, 1, 0, 4'd5,  F_RW | F_RD, K_NORM);
      add_e("ADDU",  6'h00, 6'h21, 1, 0, 4'd5,  F_RW | F_RD, K_NORM);
      add_e("SUB",   6'h00, 6'h22, 1, 0, 4'd6,  F_RW | F_RD, K_NORM);
      add_e("AND",   6'h00, 6'h24, 1, 0, 4'd7,  F_RW | F_RD, K_NORM);
      add_e("OR",    6'h00, 6'h25, 1, 0, 4'd8,  F_RW | F_RD, K_NORM);
      add_e("XOR",   6'h00, 6'h26, 1, 0, 4'd9,  F_RW | F_RD, K_NORM);
      add_e("NOR",   6'h00, 6'h27, 1, 0, 4'd10, F_RW | F_RD, K_NORM);
      add_e("SLT",   6'h00, 6'h2A, 1, 0, 4'd11, F_RW | F_RD, K_NORM);
      add_e("SLTU",  6'h00, 6'h2B, 1, 0, 4'd12, F_RW | F_RD, K_NORM);
      add_e("SLL",   6'h00, 6'h00, 1, 0, 4'd0,  F_RW | F_RD | F_SH, K_NORM);
      add_e("SRL",   6'h00, 6'h02, 1, 0, 4'd2,  F_RW | F_RD | F_SH, K_NORM);
      add_e("SRA",   6'h00, 6'h03, 1, 0, 4'd1,  F_RW | F_RD | F_SH, K_NORM);
      add_e("SRLV",  6'h00, 6'h06, 1, 0, 4'd2,  F_RW | F_RD, K_NORM);
      add_e("JR",    6'h00, 6'h08, 1, 0, 4'd0,  F_JR, K_NORM);
      add_e("SYSCALL", 6'h00, 6'h0C, 1, 0, 4'd0, F_SYS, K_SYS);
      add_e("MULT",  6'h00, 6'h18, 1, 0, 4'd0,  17'd0, K_MDU);
      add_e("MULTU", 6'h00, 6'h19, 1, 0, 4'd0,  17'd0, K_MDU);
      add_e("DIV",   6'h00, 6'h1A, 1, 0, 4'd0,  17'd0, K_MDU);
      add_e("DIVU",  6'h00, 6'h1B, 1, 0, 4'd0,  17'd0, K_MDU);
      add_e("MFHI",  6'h00, 6'h10, 1, 0, 4'd0,  F_HILO | F_RW | F_RD, K_HILO);
      add_e("MFLO",  6'h00, 6'h12, 1, 0, 4'd0,  F_HILO | F_RW | F_RD, K_HILO);
      add_e("J",     6'h02, 6'h00, 0, 0, 4'd0,  F_J, K_NORM);
      add_e("JAL",   6'h03, 6'h00, 0, 0, 4'd0,  F_JAL | F_RW, K_NORM);
      add_e("BEQ",   6'h04, 6'h00, 0, 0, 4'd0,  F_BEQ, K_NORM);
      add_e("BNE",   6'h05, 6'h00, 0, 0, 4'd0,  F_BNE, K_NORM);
      add_e("BLEZ",  6'h06, 6'h00, 0, 1, 4'd11, F_BLEZ, K_NORM);
      add_e("ADDI",  6'h08, 6'h00, 0, 0, 4'd5,  F_SRCB | F_RW | F_SEXT, K_NORM);
      add_e("ADDIU", 6'h09, 6'h00, 0, 0, 4'd5,  F_SRCB | F_RW | F_SEXT, K_NORM);
      add_e("SLTI",  6'h0A, 6'h00, 0, 0, 4'd11, F_SRCB | F_RW | F_SEXT, K_NORM);
      add_e("ANDI",  6'h0C, 6'h00, 0, 0, 4'd7,  F_SRCB | F_RW, K_NORM);
      add_e("ORI",   6'h0D, 6'h00, 0, 0, 4'd8,  F_SRCB | F_RW, K_NORM);
      add_e("LW",    6'h23, 6'h00, 0, 0, 4'd5,  F_SRCB | F_RW | F_M2R | F_SEXT, K_NORM);
      add_e("LBU",   6'h24, 6'h00, 0, 0, 4'd5,  F_SRCB | F_RW | F_M2R | F_SEXT | F_BYTE, K_NORM);
      add_e("SW",    6'h2B, 6'h00, 0, 0, 4'd5,  F_SRCB | F_MW | F_SEXT, K_NORM);
      add_e("ILL_OP",   6'h3F, 6'h00, 0, 0, 4'd0, 17'd0, K_ILL);
      add_e("ILL_FN",   6'h00, 6'h01, 1, 0, 4'd0, 17'd0, K_ILL);
      add_e("ILL_BLEZ", 6'h06, 6'h00, 0, 2, 4'd0, 17'd0, K_ILL);

      e_add = find("ADD"); e_mult = find("MULT"); e_multu = find("MULTU");
      e_mflo = find("MFLO"); e_sys = find("SYSCALL"); e_ill = find("ILL_OP");

      model_reset();
      rst = 1'b1;
      bus.id_instr = '0; bus.id_valid = 1'b0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // add, then lw / lbu
      cycle(e_add, 32'h00851020, 1, 0, 0, 0);
      cycle(find("LW"),  32'h8C820004, 1, 0, 0, 0);
      cycle(find("LBU"), 32'h90820004, 1, 0, 0, 0);
      idle(1);

      // mult followed by a waiting mflo
      busy_cnt = 0; start_cnt = 0;
      cycle(e_mult, 32'h00850018, 1, 0, 0, 0);
      repeat (6) cycle(e_mflo, 32'h00001012, 1, 0, 0, 0);
      idle(2);
      chk("mult_busy_len",  32'(busy_cnt),  32'(MDU_LAT));
      chk("mult_start_cnt", 32'(start_cnt), 32'd1);

      // ex_stall during busy, then a flushed MDU op
      busy_cnt = 0; start_cnt = 0;
      cycle(e_mult, 32'h00850018, 1, 0, 0, 0);
      repeat (3) cycle(e_add, 32'h00851020, 1, 1, 0, 0);
      idle(1);
      cycle(e_multu, gen(e_multu), 1, 0, 1, 0);
      idle(6);
      chk("stall_busy_len",  32'(busy_cnt),  32'(MDU_LAT + 3));
      chk("stall_start_cnt", 32'(start_cnt), 32'd1);

      // syscall halts until reset
      cycle(e_sys, 32'h0000000C, 1, 0, 0, 0);
      repeat (20) cycle(e_add, 32'h00851020, 1, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0, 1);
      idle(1);

      // undecodable opcode
      cycle(e_ill, 32'hFC000000, 1, 0, 0, 0);
      repeat (3) cycle(e_add, 32'h00851020, 1, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0, 1);
      idle(1);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2)      ei = e_sys;
         else if (r < 5) ei = ill_idx[$urandom_range(0, ill_idx.size() - 1)];
         else            ei = norm_idx[$urandom_range(0, norm_idx.size() - 1)];
         cycle(ei, gen(ei), $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
